// File: rtl/tl_inorder_responder_if.sv
// rtl/tl_inorder_responder_if.sv - A/D channel bundle for the in-order TileLink-UL responder
interface tl_inorder_responder_if #(
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 3,
  parameter int DATA_W   = 32
);
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [SOURCE_W-1:0] a_source;
  logic [SIZE_W-1:0]   a_size;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [SOURCE_W-1:0] d_source;
  logic [SIZE_W-1:0]   d_size;
  logic                d_denied;
  logic [DATA_W-1:0]   d_data;

  modport master (
    output a_valid, a_opcode, a_source, a_size, d_ready,
    input  a_ready, d_valid, d_opcode, d_source, d_size, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_source, a_size, d_ready,
    output a_ready, d_valid, d_opcode, d_source, d_size, d_denied, d_data
  );
endinterface

// File: rtl/tl_inorder_responder.sv
// rtl/tl_inorder_responder.sv - TileLink-UL stub slave answering requests strictly in order
module tl_inorder_responder #(
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 3,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_inorder_responder_if.slave bus
);
  localparam int BEAT_LG    = $clog2(DATA_W / 8);
  localparam int CNT_RAW    = (1 << SIZE_W) - BEAT_LG;
  localparam int CNT_W      = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int PTR_W      = $clog2(DEPTH);
  // Read data places the beat index in the low nibble and the source above it.
  localparam int DATA_CNT_W = 4;

  typedef enum logic [1:0] {K_DATA, K_ACK, K_DENY} kind_e;
  typedef enum logic {S_IDLE, S_SEND} state_e;

  // Index of the last beat of a transfer of 2^size bytes.
  function automatic logic [CNT_W-1:0] last_idx(input logic [SIZE_W-1:0] size);
    if (int'(size) <= BEAT_LG) return '0;
    return CNT_W'((1 << (int'(size) - BEAT_LG)) - 1);
  endfunction

  logic [CNT_W-1:0]    a_acnt_q, a_acnt_d;
  logic [2:0]          a_op_q, a_op_d;
  logic [SOURCE_W-1:0] a_src_q, a_src_d;
  logic [SIZE_W-1:0]   a_size_q, a_size_d;
  logic                a_ready_q, a_ready_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [CNT_W-1:0]    d_dcnt_q, d_dcnt_d;
  state_e              state_q, state_d;

  kind_e               q_kind_q [DEPTH];
  logic [SOURCE_W-1:0] q_src_q  [DEPTH];
  logic [SIZE_W-1:0]   q_size_q [DEPTH];

  logic [2:0]          cur_op;
  logic [SOURCE_W-1:0] cur_src;
  logic [SIZE_W-1:0]   cur_size;
  logic                a_fire, a_first, a_last, enq, d_fire, d_last, deq, send;
  kind_e               enq_kind, head_kind;
  logic [SOURCE_W-1:0] head_src;
  logic [SIZE_W-1:0]   head_size;

  assign send      = (state_q == S_SEND);
  assign head_kind = q_kind_q[rd_ptr_q];
  assign head_src  = q_src_q[rd_ptr_q];
  assign head_size = q_size_q[rd_ptr_q];

  // Next-state logic: A-beat counting, enqueue on last A beat, pop on last D beat.
  always_comb begin
    a_first  = (a_acnt_q == '0);
    cur_op   = a_first ? bus.a_opcode : a_op_q;
    cur_src  = a_first ? bus.a_source : a_src_q;
    cur_size = a_first ? bus.a_size   : a_size_q;
    a_fire   = bus.a_valid & a_ready_q;

    if (cur_op == 3'd4)                         enq_kind = K_DATA;
    else if (cur_op == 3'd0 || cur_op == 3'd1)  enq_kind = K_ACK;
    else                                        enq_kind = K_DENY;

    // Only Puts span several A beats; Get and unsupported opcodes are single-beat.
    a_last = (enq_kind != K_ACK) || (a_acnt_q == last_idx(cur_size));
    enq    = a_fire & a_last;

    a_acnt_d = a_acnt_q;
    if (a_fire) a_acnt_d = a_last ? '0 : a_acnt_q + 1'b1;
    a_op_d   = (a_fire & a_first) ? bus.a_opcode : a_op_q;
    a_src_d  = (a_fire & a_first) ? bus.a_source : a_src_q;
    a_size_d = (a_fire & a_first) ? bus.a_size   : a_size_q;

    d_fire = send & bus.d_ready;
    d_last = (head_kind != K_DATA) || (d_dcnt_q == last_idx(head_size));
    deq    = d_fire & d_last;

    d_dcnt_d = d_dcnt_q;
    if (d_fire) d_dcnt_d = d_last ? '0 : d_dcnt_q + 1'b1;

    wr_ptr_d  = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d  = rd_ptr_q + PTR_W'(deq);
    count_d   = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    // a_ready tracks the registered count, so a pop never frees a slot in the same cycle.
    a_ready_d = (count_d != (PTR_W+1)'(DEPTH));
    // SEND persists across back-to-back entries; IDLE only once the queue drains.
    state_d   = (count_d != '0) ? S_SEND : S_IDLE;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_acnt_q  <= '0;
      a_op_q    <= '0;
      a_src_q   <= '0;
      a_size_q  <= '0;
      a_ready_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      d_dcnt_q  <= '0;
      state_q   <= S_IDLE;
    end else begin
      a_acnt_q  <= a_acnt_d;
      a_op_q    <= a_op_d;
      a_src_q   <= a_src_d;
      a_size_q  <= a_size_d;
      a_ready_q <= a_ready_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      d_dcnt_q  <= d_dcnt_d;
      state_q   <= state_d;
    end
  end

  // Queue storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_kind_q[wr_ptr_q] <= enq_kind;
      q_src_q[wr_ptr_q]  <= cur_src;
      q_size_q[wr_ptr_q] <= cur_size;
    end
  end

  assign bus.a_ready  = a_ready_q;
  assign bus.d_valid  = send;
  assign bus.d_opcode = (send && head_kind == K_DATA) ? 3'd1 : 3'd0;
  assign bus.d_source = send ? head_src : '0;
  assign bus.d_size   = send ? head_size : '0;
  assign bus.d_denied = send && (head_kind == K_DENY);
  assign bus.d_data   = (send && head_kind == K_DATA)
                      ? ((DATA_W'(head_src) << DATA_CNT_W)
                         | (DATA_W'(d_dcnt_q) & DATA_W'((1 << DATA_CNT_W) - 1)))
                      : '0;
endmodule

// File: tb/tb_tl_inorder_responder.sv
// tb/tb_tl_inorder_responder.sv - randomized and directed bench for tl_inorder_responder
module tb_tl_inorder_responder;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;

  tl_inorder_responder_if #(.SOURCE_W(4), .SIZE_W(3), .DATA_W(32)) bus ();

  tl_inorder_responder #(.SOURCE_W(4), .SIZE_W(3), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  src;
    logic [2:0]  size;
    logic        denied;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  int          entries_n;
  int          m_acnt, m_need;
  logic [2:0]  m_op, m_size;
  logic [3:0]  m_src;
  bit          need_new;
  int          n_checks, n_fail;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Number of 4-byte beats needed to move 2^size bytes.
  function automatic int beats_of(input logic [2:0] sz);
    int bytes;
    bytes = 1 << sz;
    return (bytes <= 4) ? 1 : bytes / 4;
  endfunction

  task automatic push_response();
    int nb;
    beat_t b;
    bit is_get, is_put;
    is_get = (m_op == 3'd4);
    is_put = (m_op == 3'd0) || (m_op == 3'd1);
    nb = is_get ? beats_of(m_size) : 1;
    for (int i = 0; i < nb; i++) begin
      b.op     = is_get ? 3'd1 : 3'd0;
      b.src    = m_src;
      b.size   = m_size;
      b.denied = !(is_get || is_put);
      b.data   = is_get ? (32'(m_src) * 32'd16 + 32'(i % 16)) : 32'd0;
      b.last   = (i == nb - 1);
      exp_q.push_back(b);
    end
    entries_n++;
  endtask

  task automatic accept_beat(input logic [2:0] op, input logic [3:0] src, input logic [2:0] sz);
    if (m_acnt == 0) begin
      m_op   = op;
      m_src  = src;
      m_size = sz;
      m_need = (op == 3'd0 || op == 3'd1) ? beats_of(sz) : 1;
    end
    m_acnt++;
    if (m_acnt == m_need) begin
      push_response();
      m_acnt   = 0;
      need_new = 1;
    end
  endtask

  task automatic check_outputs();
    check_val("a_ready", 64'(bus.a_ready), 64'(entries_n < DEPTH));
    check_val("d_valid", 64'(bus.d_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_val("d_opcode", 64'(bus.d_opcode), 64'(exp_q[0].op));
      check_val("d_source", 64'(bus.d_source), 64'(exp_q[0].src));
      check_val("d_size",   64'(bus.d_size),   64'(exp_q[0].size));
      check_val("d_denied", 64'(bus.d_denied), 64'(exp_q[0].denied));
      check_val("d_data",   64'(bus.d_data),   64'(exp_q[0].data));
    end else begin
      check_val("idle_d_data",   64'(bus.d_data),   64'd0);
      check_val("idle_d_opcode", 64'(bus.d_opcode), 64'd0);
      check_val("idle_d_source", 64'(bus.d_source), 64'd0);
    end
  endtask

  // One clock: check current outputs, apply inputs, advance the model, step past the edge.
  task automatic cycle(input logic av, input logic [2:0] op, input logic [3:0] src,
                       input logic [2:0] sz, input logic dr);
    bit rdy;
    beat_t b;
    bus.a_valid  = av;
    bus.a_opcode = op;
    bus.a_source = src;
    bus.a_size   = sz;
    bus.d_ready  = dr;
    check_outputs();
    rdy = (entries_n < DEPTH);
    if (dr && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      if (b.last) entries_n--;
    end
    if (av && rdy) accept_beat(op, src, sz);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset        = 1'b1;
    bus.a_valid  = 1'b0;
    bus.d_ready  = 1'b0;
    @(posedge clock);
    #1;
    check_val("rst_a_ready",  64'(bus.a_ready),  64'd0);
    check_val("rst_d_valid",  64'(bus.d_valid),  64'd0);
    check_val("rst_d_opcode", 64'(bus.d_opcode), 64'd0);
    check_val("rst_d_source", 64'(bus.d_source), 64'd0);
    check_val("rst_d_size",   64'(bus.d_size),   64'd0);
    check_val("rst_d_denied", 64'(bus.d_denied), 64'd0);
    check_val("rst_d_data",   64'(bus.d_data),   64'd0);
    reset = 1'b0;
    exp_q.delete();
    entries_n = 0;
    m_acnt    = 0;
    need_new  = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 4'd0, 3'd0, dr);
  endtask

  initial begin
    logic [2:0] c_op, c_sz, op, sz;
    logic [3:0] c_src, src;
    logic       av, dr;
    int         r;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.a_valid  = 1'b0;
    bus.a_opcode = 3'd0;
    bus.a_source = 4'd0;
    bus.a_size   = 3'd0;
    bus.d_ready  = 1'b0;
    reset_dut();

    // Single-beat Get
    cycle(1'b1, 3'd4, 4'd3, 3'd2, 1'b0);
    check_val("tp_get_valid", 64'(bus.d_valid), 64'd1);
    check_val("tp_get_data",  64'(bus.d_data),  64'h30);
    idle(2, 1'b1);

    // Four-beat Get
    cycle(1'b1, 3'd4, 4'd5, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_val("tp_burst_data", 64'(bus.d_data), 64'(32'h50 + 32'(i)));
      cycle(1'b0, 3'd0, 4'd0, 3'd0, 1'b1);
    end
    idle(1, 1'b1);

    // Two-beat PutFull with garbage on the second beat
    cycle(1'b1, 3'd0, 4'd2, 3'd3, 1'b1);
    idle(1, 1'b1);
    check_val("tp_put_no_early", 64'(bus.d_valid), 64'd0);
    cycle(1'b1, 3'd7, 4'd15, 3'd7, 1'b1);
    check_val("tp_put_ack_src", 64'(bus.d_source), 64'd2);
    idle(2, 1'b1);

    // Fill the queue, hold D back, then release
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'd4, 4'(i), 3'd2, 1'b0);
    check_val("tp_full_ready", 64'(bus.a_ready), 64'd0);
    cycle(1'b1, 3'd4, 4'd9, 3'd2, 1'b0);
    cycle(1'b1, 3'd4, 4'd9, 3'd2, 1'b0);
    cycle(1'b1, 3'd4, 4'd9, 3'd2, 1'b1);
    check_val("tp_ready_after_pop", 64'(bus.a_ready), 64'd1);
    idle(8, 1'b1);

    // Unsupported opcode, then a Get
    cycle(1'b1, 3'd6, 4'd7, 3'd0, 1'b0);
    check_val("tp_deny", 64'(bus.d_denied), 64'd1);
    idle(1, 1'b1);
    cycle(1'b1, 3'd4, 4'd2, 3'd2, 1'b0);
    check_val("tp_no_deny", 64'(bus.d_denied), 64'd0);
    idle(2, 1'b1);

    // Reset in the middle of a four-beat Get
    cycle(1'b1, 3'd4, 4'd5, 3'd4, 1'b1);
    idle(2, 1'b1);
    reset_dut();
    cycle(1'b1, 3'd4, 4'd1, 3'd2, 1'b0);
    check_val("tp_post_rst_data", 64'(bus.d_data), 64'h10);
    idle(3, 1'b1);

    // Randomized traffic
    need_new = 1;
    c_op = 3'd0; c_sz = 3'd0; c_src = 4'd0;
    for (int n = 0; n < 4000; n++) begin
      av = (($urandom % 10) < 7);
      dr = (($urandom % 10) < 6);
      if (m_acnt == 0) begin
        if (need_new) begin
          r = int'($urandom % 8);
          if (r < 3)       c_op = 3'd4;
          else if (r == 3) c_op = 3'd0;
          else if (r == 4) c_op = 3'd1;
          else begin
            r = int'($urandom % 5);
            c_op = (r < 2) ? 3'(r + 2) : 3'(r + 3);
          end
          c_src    = 4'($urandom % 16);
          c_sz     = 3'($urandom % 8);
          need_new = 0;
        end
        op = c_op; src = c_src; sz = c_sz;
      end else begin
        op  = 3'($urandom % 8);
        src = 4'($urandom % 16);
        sz  = 3'($urandom % 8);
      end
      cycle(av, op, src, sz, dr);
    end

    // Drain with a bounded number of cycles
    for (int i = 0; i < 300; i++) cycle(1'b0, 3'd0, 4'd0, 3'd0, 1'b1);
    check_val("drain_d_valid", 64'(bus.d_valid), 64'd0);
    check_val("drain_a_ready", 64'(bus.a_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
